// File: rtl/uart_baud_gen.sv
// UART baud generator: divides clk by a run-time divisor into os/mid/bit ticks and TxC.
// Latency: ticks are decoded combinationally from the registers (zero latency); divisor visible on div_q one cycle after div_wr.
// Backpressure: none; en=0 freezes all counters and TxC, while div_wr/resync act regardless of en.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   en                 count enable
//   div_in, div_wr     new divisor value and its one-cycle load strobe
//   resync             one-cycle strobe restarting the bit phase
//   div_q              current divisor register
//   os_tick            pulse every div_eff enabled cycles
//   mid_tick, bit_tick pulses at the middle / end of each bit period
//   TxC                bit clock, toggles on each bit_tick
module uart_baud_gen #(
    parameter int CNT_W       = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 14
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_wr,
    input  logic             resync,
    output logic [CNT_W-1:0] div_q,
    output logic             os_tick,
    output logic             mid_tick,
    output logic             bit_tick,
    output logic             TxC
);

    localparam int               OS_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] div_reg_q, div_reg_d;
    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [OS_W-1:0]  os_cnt_q,  os_cnt_d;
    logic             txc_q,     txc_d;

    logic [CNT_W-1:0] div_eff;
    logic             pre_wrap;

    // A programmed divisor of 0 behaves as 1 so the prescaler still wraps every cycle.
    assign div_eff  = (div_reg_q == '0) ? CNT_W'(1) : div_reg_q;
    assign pre_wrap = (pre_cnt_q == div_eff - CNT_W'(1));

    // div_wr and resync both clear the counters this cycle, so they suppress the ticks.
    // resetn gating keeps the ticks low throughout reset even for a divisor of 1.
    assign os_tick  = resetn & en & ~resync & ~div_wr & pre_wrap;
    assign mid_tick = os_tick & (os_cnt_q == OS_MID);
    assign bit_tick = os_tick & (os_cnt_q == OS_LAST);

    assign div_q = div_reg_q;
    assign TxC   = txc_q;

    always_comb begin
        div_reg_d = div_reg_q;
        pre_cnt_d = pre_cnt_q;
        os_cnt_d  = os_cnt_q;
        txc_d     = txc_q;
        if (div_wr) begin
            div_reg_d = div_in;
            pre_cnt_d = '0;
            os_cnt_d  = '0;
        end else if (resync) begin
            pre_cnt_d = '0;
            os_cnt_d  = '0;
        end else if (en) begin
            if (pre_wrap) begin
                pre_cnt_d = '0;
                // OVERSAMPLE is a power of two, so the natural wrap gives OVERSAMPLE-1 -> 0.
                os_cnt_d  = os_cnt_q + OS_W'(1);
            end else begin
                pre_cnt_d = pre_cnt_q + CNT_W'(1);
            end
            if (bit_tick) begin
                txc_d = ~txc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_reg_q <= DIV_RST;
            pre_cnt_q <= '0;
            os_cnt_q  <= '0;
            txc_q     <= 1'b0;
        end else begin
            div_reg_q <= div_reg_d;
            pre_cnt_q <= pre_cnt_d;
            os_cnt_q  <= os_cnt_d;
            txc_q     <= txc_d;
        end
    end

endmodule
